// File: rtl/ripple_count_snapshot_if.sv
// ripple_count_snapshot_if: count, request and snapshot handshake signals of the ripple-count capture stage
interface ripple_count_snapshot_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] cnt_i;
    logic [WIDTH-1:0] cmp_i;
    logic             snap_req_i;
    logic             snap_ready_i;
    logic [WIDTH-1:0] snap_o;
    logic             snap_valid_o;
    logic             match_o;
    logic             wrap_o;
    logic             stale_o;
    logic             busy_o;
    modport master (
        output cnt_i, cmp_i, snap_req_i, snap_ready_i,
        input  snap_o, snap_valid_o, match_o, wrap_o, stale_o, busy_o
    );
    modport slave (
        input  cnt_i, cmp_i, snap_req_i, snap_ready_i,
        output snap_o, snap_valid_o, match_o, wrap_o, stale_o, busy_o
    );
endinterface

// File: rtl/ripple_count_snapshot.sv
// ripple_count_snapshot: synchronise a ripple count, wait to settle, capture two identical samples, offer via valid/ready
module ripple_count_snapshot #(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 8
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    ripple_count_snapshot_if.slave bus
);
    localparam int WW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int RW = $clog2(MAX_RETRY);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HOLD} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] s1_q, s_q, p_q;
    logic [WIDTH-1:0] last_q, last_d, snap_q, snap_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             match_q, match_d, wrap_q, wrap_d, stale_q, stale_d;
    logic             capture;
    // a capture is forced once the retry budget is spent, flagged through stale
    assign capture = (s_q == p_q) || (retry_q == RW'(MAX_RETRY - 1));
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        retry_d = retry_q;
        last_d  = last_q;
        snap_d  = snap_q;
        match_d = match_q;
        wrap_d  = wrap_q;
        stale_d = stale_q;
        case (state_q)
            S_IDLE: if (bus.snap_req_i) begin
                state_d = S_SETTLE;
                wait_d  = '0;
                retry_d = '0;
            end
            S_SETTLE: begin
                wait_d  = wait_q + 1'b1;
                state_d = (wait_q == WW'(SETTLE - 1)) ? S_SAMPLE : S_SETTLE;
            end
            S_SAMPLE: if (capture) begin
                snap_d  = s_q;
                match_d = s_q == bus.cmp_i;
                wrap_d  = s_q < last_q;
                last_d  = s_q;
                stale_d = s_q != p_q;
                state_d = S_HOLD;
            end else begin
                retry_d = retry_q + 1'b1;
            end
            S_HOLD: state_d = bus.snap_ready_i ? S_IDLE : S_HOLD;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            s1_q    <= '0;
            s_q     <= '0;
            p_q     <= '0;
            last_q  <= '0;
            wait_q  <= '0;
            retry_q <= '0;
            snap_q  <= '0;
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= bus.cnt_i;
            s_q     <= s1_q;
            p_q     <= s_q;
            last_q  <= last_d;
            wait_q  <= wait_d;
            retry_q <= retry_d;
            snap_q  <= snap_d;
            match_q <= match_d;
            wrap_q  <= wrap_d;
            stale_q <= stale_d;
        end
    end
    assign bus.snap_o       = snap_q;
    assign bus.snap_valid_o = state_q == S_HOLD;
    assign bus.match_o      = match_q;
    assign bus.wrap_o       = wrap_q;
    assign bus.stale_o      = stale_q;
    assign bus.busy_o       = state_q != S_IDLE;
endmodule

// File: tb/tb_ripple_count_snapshot.sv
// tb_ripple_count_snapshot: directed and randomized snapshots checked against a cycle-history reference model
module tb_ripple_count_snapshot;
    localparam int W  = 4;
    localparam int ST = 2;
    localparam int MR = 8;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   mode   = 0;
    int   lat;
    logic [W-1:0] hist [0:4095];
    logic [W-1:0] last_m = '0;
    ripple_count_snapshot_if #(.WIDTH(W)) bus ();
    ripple_count_snapshot #(.WIDTH(W), .SETTLE(ST), .MAX_RETRY(MR)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );
    always #5 clk_i = ~clk_i;
    // cnt_i as seen at every edge; the synchroniser holds zeros while reset is asserted
    always @(posedge clk_i) begin
        hist[cyc % 4096] <= rst_ni ? bus.cnt_i : '0;
        cyc <= cyc + 1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk_i);
        if (mode == 1 && $urandom_range(0, 2) == 0) bus.cnt_i = W'($urandom);
        else if (mode == 2) bus.cnt_i = (bus.cnt_i == W'(7)) ? W'(8) : W'(7);
    endtask
    // request, wait for valid, compare against the model, optional backpressure, then handshake
    task automatic snap(input int hold, input bit xreq, output int latency);
        int e0, n, r;
        logic [W-1:0] cap, pv;
        latency = -1;
        chk("idle_before_req", bus.busy_o, 0);
        bus.snap_req_i = 1'b1;
        e0 = cyc;
        tick();
        bus.snap_req_i = 1'b0;
        chk("busy_after_req", bus.busy_o, 1);
        n = 0;
        while (!bus.snap_valid_o && n < 40) begin
            tick();
            n++;
        end
        if (!bus.snap_valid_o) begin
            chk("valid_timeout", 0, 1);
            return;
        end
        for (r = 0; r < MR; r++) begin
            cap = hist[(e0 + ST + r - 1) % 4096];
            pv  = hist[(e0 + ST + r - 2) % 4096];
            if (cap == pv || r == MR - 1) break;
        end
        latency = cyc - 1 - e0;
        chk("latency", latency, ST + 1 + r);
        chk("snap", bus.snap_o, cap);
        chk("match", bus.match_o, cap == bus.cmp_i);
        chk("wrap", bus.wrap_o, cap < last_m);
        chk("stale", bus.stale_o, cap != pv);
        last_m = cap;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", bus.snap_valid_o, 1);
            chk("hold_snap", bus.snap_o, cap);
            bus.snap_req_i = xreq && i == 1;
            tick();
        end
        bus.snap_ready_i = 1'b1;
        bus.snap_req_i   = xreq;
        tick();
        bus.snap_ready_i = 1'b0;
        bus.snap_req_i   = 1'b0;
        chk("valid_drop", bus.snap_valid_o, 0);
        chk("busy_drop", bus.busy_o, 0);
        chk("snap_kept", bus.snap_o, cap);
        tick();
        chk("no_queued_req", bus.busy_o, 0);
    endtask
    initial begin
        bus.cnt_i        = '0;
        bus.cmp_i        = '0;
        bus.snap_req_i   = 1'b0;
        bus.snap_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_snap", bus.snap_o, 0);
        chk("rst_valid", bus.snap_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_match", bus.match_o, 0);
        chk("rst_wrap", bus.wrap_o, 0);
        chk("rst_stale", bus.stale_o, 0);
        #2 rst_ni = 1'b1;
        bus.cnt_i = W'(5);
        bus.cmp_i = W'(5);
        repeat (10) tick();
        snap(1, 1'b0, lat);
        chk("stable_lat", lat, 3);
        chk("stable_snap", bus.snap_o, 5);
        chk("stable_match", bus.match_o, 1);
        chk("stable_wrap", bus.wrap_o, 0);
        chk("stable_stale", bus.stale_o, 0);
        mode = 1;
        bus.cmp_i = W'($urandom);
        snap(6, 1'b1, lat);
        mode = 0;
        bus.cnt_i = W'(14);
        repeat (5) tick();
        snap(1, 1'b0, lat);
        chk("wrap_e_snap", bus.snap_o, 14);
        bus.cnt_i = W'(3);
        repeat (5) tick();
        snap(1, 1'b0, lat);
        chk("wrap_3_flag", bus.wrap_o, 1);
        bus.cnt_i = W'(7);
        repeat (5) tick();
        snap(1, 1'b0, lat);
        chk("wrap_7_flag", bus.wrap_o, 0);
        mode = 2;
        snap(2, 1'b0, lat);
        mode = 0;
        chk("unstable_lat", lat, ST + MR);
        chk("unstable_stale", bus.stale_o, 1);
        chk("unstable_val", bus.snap_o == W'(7) || bus.snap_o == W'(8), 1);
        bus.cnt_i = W'(7);
        repeat (5) tick();
        bus.cnt_i = W'(6);
        tick();
        bus.cnt_i = W'(4);
        tick();
        bus.cnt_i = W'(0);
        tick();
        bus.cnt_i = W'(8);
        snap(1, 1'b0, lat);
        chk("glitch_snap", bus.snap_o, 8);
        chk("glitch_stale", bus.stale_o, 0);
        mode = 2;
        tick();
        bus.snap_req_i = 1'b1;
        tick();
        bus.snap_req_i = 1'b0;
        repeat (4) tick();
        chk("mid_sample_busy", bus.busy_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", bus.busy_o, 0);
        chk("async_rst_valid", bus.snap_valid_o, 0);
        chk("async_rst_snap", bus.snap_o, 0);
        chk("async_rst_stale", bus.stale_o, 0);
        last_m = '0;
        repeat (2) tick();
        #2 rst_ni = 1'b1;
        mode = 0;
        bus.cnt_i = W'(9);
        bus.cmp_i = W'(9);
        repeat (4) tick();
        snap(1, 1'b0, lat);
        chk("post_rst_snap", bus.snap_o, 9);
        chk("post_rst_match", bus.match_o, 1);
        mode = 1;
        for (int k = 0; k < 20; k++) begin
            bus.cmp_i = $urandom_range(0, 1) ? bus.cnt_i : W'($urandom);
            repeat ($urandom_range(0, 4)) tick();
            snap($urandom_range(0, 4), 1'($urandom_range(0, 1)), lat);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
